instr_fetch_unit: RTL and testbench

Instruction fetch stage directly downstream of the program counter and its PCPlus4/PCTarget next-PC logic. It owns the fetch address, issues word requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned words in a small FIFO. The FIFO head forms the IF/ID register consumed by decode. Taken branch/jump redirects from the PC-select path flush the stage.

---
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/instr_fetch_unit.sv | 183 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus: one word request at a time,
// accepted by gnt, answered later by rvalid/rdata.
interface imem_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [31:0]     rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch address, keeps one imem request in flight and
// queues returned words in a small FIFO whose head is the IF/ID register.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | just out of reset, no request yet
// REQ    | request to fetch address offered while the FIFO has room
// WAIT   | granted request outstanding, waiting for rvalid (maybe discarded)
module instr_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_d,
  imem_if.master          imem,
  output logic            ifid_valid,
  output logic [31:0]     ifid_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pcplus4
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_discard;
  logic            w_discard_nxt;

  // Fetch address is kept as a word index so the low bits can never be set.
  logic [XLEN-3:0] r_fetch_word;
  logic [XLEN-1:0] r_req_pc;

  logic [31:0]     r_buf_instr [BUF_DEPTH];
  logic [XLEN-1:0] r_buf_pc    [BUF_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic            w_req;
  logic            w_grant;
  logic            w_resp;
  logic            w_push;
  logic            w_pop;
  logic            w_head_valid;
  logic            w_has_room;
  logic [XLEN-1:0] w_fetch_addr;
  logic            w_unused;

  assign w_fetch_addr = {r_fetch_word, 2'b00};
  assign w_has_room   = (r_count < CNT_W'(BUF_DEPTH));
  assign w_head_valid = (r_count != '0);
  assign w_grant      = w_req && imem.gnt;
  assign w_resp       = (r_state == S_WAIT) && imem.rvalid;
  assign w_push       = w_resp && !r_discard && !redirect_valid;
  assign w_pop        = w_head_valid && !stall_d && !redirect_valid;
  assign w_unused     = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  // A redirect that lands while a request is (or just became) outstanding
  // must swallow that response before fetching from the new target.
  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    case (r_state)
      S_IDLE: begin
        w_state_nxt   = S_REQ;
        w_discard_nxt = 1'b0;
      end
      S_REQ: begin
        if (w_grant) begin
          w_state_nxt   = S_WAIT;
          w_discard_nxt = redirect_valid;
        end else begin
          w_discard_nxt = 1'b0;
        end
      end
      S_WAIT: begin
        if (imem.rvalid) begin
          w_state_nxt   = S_REQ;
          w_discard_nxt = 1'b0;
        end else if (redirect_valid) begin
          w_discard_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_discard_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_req = 1'b0;
    if (r_state == S_REQ && w_has_room) begin
      w_req = 1'b1;
    end
  end

  assign imem.req  = w_req;
  assign imem.addr = w_fetch_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_word <= RESET_PC[XLEN-1:2];
      r_req_pc     <= '0;
    end else begin
      if (redirect_valid) begin
        r_fetch_word <= redirect_pc[XLEN-1:2];
      end else if (w_grant) begin
        r_fetch_word <= r_fetch_word + (XLEN-2)'(1);
      end
      if (w_grant) begin
        r_req_pc <= w_fetch_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_instr[r_wptr] <= imem.rdata;
      r_buf_pc[r_wptr]    <= r_req_pc;
    end
  end

  always_comb begin
    ifid_valid   = w_head_valid;
    ifid_instr   = NOP_INSTR;
    ifid_pc      = '0;
    ifid_pcplus4 = '0;
    if (w_head_valid) begin
      ifid_instr   = r_buf_instr[r_rptr];
      ifid_pc      = r_buf_pc[r_rptr];
      ifid_pcplus4 = r_buf_pc[r_rptr] + XLEN'(4);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a configurable imem responder, a PC-stream
// model checked every cycle, and directed scenarios with literal expectations.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall_d = 1'b0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pcplus4;

  imem_if #(.XLEN(32)) imem ();

  int total = 0;
  int bad   = 0;

  int   gnt_delay = 0;
  int   rsp_delay = 1;
  logic gnt_block = 1'b0;
  logic corrupt   = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(2), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .stall_d(stall_d),
    .imem(imem),
    .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc),
    .ifid_pcplus4(ifid_pcplus4)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  // Memory responder: gnt after gnt_delay cycles of req, rvalid rsp_delay cycles after gnt.
  int          r_gwait = 0;
  logic        r_pend  = 1'b0;
  int          r_cnt   = 0;
  logic [31:0] r_paddr = 32'h0;
  logic        r_pbad  = 1'b0;

  assign imem.gnt    = imem.req && !gnt_block && (r_gwait >= gnt_delay);
  assign imem.rvalid = r_pend && (r_cnt == 0);
  assign imem.rdata  = r_pbad ? 32'hDEAD_BEEF : memf(r_paddr);

  always @(posedge clk) begin
    if (imem.req && !imem.gnt) r_gwait <= r_gwait + 1;
    else                       r_gwait <= 0;
    if (imem.rvalid) r_pend <= 1'b0;
    if (imem.req && imem.gnt) begin
      r_pend  <= 1'b1;
      r_cnt   <= rsp_delay - 1;
      r_paddr <= imem.addr;
      r_pbad  <= corrupt;
    end else if (r_pend && r_cnt != 0) begin
      r_cnt <= r_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: decode sees a contiguous word stream from the last redirect target,
  // and requests walk the same stream one word per grant.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_fetch = 32'h0;
  logic [31:0] m_hold_addr = 32'h0;
  logic        m_hold = 1'b0;
  logic        m_after_redir = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_pc = 32'h0;
      m_fetch = 32'h0;
      m_hold = 1'b0;
      m_after_redir = 1'b0;
    end else begin
      m_hold = imem.req && !imem.gnt && !redirect_valid;
      m_hold_addr = imem.addr;
      m_after_redir = redirect_valid;
      if (redirect_valid) begin
        m_pc    = {redirect_pc[31:2], 2'b00};
        m_fetch = {redirect_pc[31:2], 2'b00};
      end else begin
        if (ifid_valid && !stall_d) m_pc = m_pc + 32'd4;
        if (imem.req && imem.gnt) m_fetch = m_fetch + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_valid", 32'(ifid_valid), 32'd0);
      check("rst_req", 32'(imem.req), 32'd0);
      check("rst_instr", ifid_instr, NOP);
      check("rst_pc", ifid_pc, 32'd0);
    end else begin
      if (m_after_redir) check("valid_after_redirect", 32'(ifid_valid), 32'd0);
      if (m_hold) begin
        check("req_hold", 32'(imem.req), 32'd1);
        check("addr_hold", imem.addr, m_hold_addr);
      end
      if (imem.req) check("fetch_addr", imem.addr, m_fetch);
      if (ifid_valid) begin
        check("ifid_pc", ifid_pc, m_pc);
        check("ifid_instr", ifid_instr, memf(m_pc));
        check("ifid_pcplus4", ifid_pcplus4, m_pc + 32'd4);
      end else begin
        check("idle_instr", ifid_instr, NOP);
        check("idle_pc", ifid_pc, 32'd0);
        check("idle_pcplus4", ifid_pcplus4, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    stall_d = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_req(input string name, input int limit);
    for (int i = 0; i < limit && !imem.req; i++) tick();
    check(name, 32'(imem.req), 32'd1);
  endtask

  task automatic wait_valid(input string name, input int limit);
    for (int i = 0; i < limit && !ifid_valid; i++) tick();
    check(name, 32'(ifid_valid), 32'd1);
  endtask

  initial begin
    // 1: reset release, zero-wait memory
    do_reset();
    check("t1_rst_valid", 32'(ifid_valid), 32'd0);
    check("t1_rst_instr", ifid_instr, NOP);
    check("t1_rst_pcp4", ifid_pcplus4, 32'd0);
    check("t1_rst_addr", imem.addr, 32'h0);
    tick();
    check("t1_req0", 32'(imem.req), 32'd1);
    check("t1_addr0", imem.addr, 32'h0);
    tick();
    check("t1_wait_req", 32'(imem.req), 32'd0);
    check("t1_wait_valid", 32'(ifid_valid), 32'd0);
    tick();
    check("t1_first_valid", 32'(ifid_valid), 32'd1);
    check("t1_first_pc", ifid_pc, 32'h0);
    check("t1_first_pcp4", ifid_pcplus4, 32'h4);
    check("t1_first_instr", ifid_instr, 32'hC0DE_0000);
    check("t1_addr4", imem.addr, 32'h4);
    tick();
    check("t1_drain_valid", 32'(ifid_valid), 32'd0);
    tick();
    check("t1_second_pc", ifid_pc, 32'h4);
    check("t1_addr8", imem.addr, 32'h8);
    repeat (4) tick();

    // 2: decode stalled, FIFO fills and fetch pauses
    do_reset();
    stall_d = 1'b1;
    repeat (12) tick();
    check("t2_full_req", 32'(imem.req), 32'd0);
    check("t2_full_addr", imem.addr, 32'h8);
    check("t2_full_head", ifid_pc, 32'h0);
    stall_d = 1'b0;
    tick();
    check("t2_head4", ifid_pc, 32'h4);
    check("t2_req8", 32'(imem.req), 32'd1);
    check("t2_addr8", imem.addr, 32'h8);
    tick();
    check("t2_empty", 32'(ifid_valid), 32'd0);
    repeat (4) tick();

    // 3: redirect while waiting, late response is dropped
    do_reset();
    rsp_delay = 3;
    wait_req("t3_wait_req", 10);
    corrupt = 1'b1;
    tick();
    corrupt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("t3_req_off", 32'(imem.req), 32'd0);
    wait_req("t3_req_new", 10);
    check("t3_addr100", imem.addr, 32'h100);
    wait_valid("t3_valid", 10);
    check("t3_pc100", ifid_pc, 32'h100);
    check("t3_instr100", ifid_instr, 32'hC0DE_0100);
    rsp_delay = 1;
    repeat (4) tick();

    // 4: redirect to unaligned target together with grant of 0x10
    do_reset();
    for (int i = 0; i < 40 && !(imem.req && imem.addr == 32'h10); i++) tick();
    check("t4_reach10", imem.addr, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    tick();
    redirect_valid = 1'b0;
    check("t4_req_off", 32'(imem.req), 32'd0);
    check("t4_addr200", imem.addr, 32'h200);
    wait_req("t4_req_new", 10);
    check("t4_addr200b", imem.addr, 32'h200);
    wait_valid("t4_valid", 10);
    check("t4_pc200", ifid_pc, 32'h200);
    check("t4_instr200", ifid_instr, 32'hC0DE_0200);
    repeat (4) tick();

    // 5: grant held off for four request cycles
    gnt_delay = 4;
    do_reset();
    begin
      int n;
      n = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (imem.req && imem.gnt) break;
        if (imem.req) n++;
      end
      check("t5_gnt_wait", 32'(n), 32'd4);
      check("t5_addr_at_gnt", imem.addr, 32'h0);
    end
    tick();
    check("t5_addr_after", imem.addr, 32'h4);
    check("t5_req_after", 32'(imem.req), 32'd0);
    gnt_delay = 0;
    repeat (6) tick();

    // 6: reset during WAIT, stale response arrives afterwards
    do_reset();
    rsp_delay = 4;
    repeat (3) tick();
    wait_req("t6_wait_req", 10);
    corrupt = 1'b1;
    tick();
    corrupt = 1'b0;
    gnt_block = 1'b1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(ifid_valid), 32'd0);
    check("t6_rst_req", 32'(imem.req), 32'd0);
    check("t6_rst_instr", ifid_instr, NOP);
    check("t6_rst_pc", ifid_pc, 32'd0);
    check("t6_rst_addr", imem.addr, 32'h0);
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    check("t6_stale_valid", 32'(ifid_valid), 32'd0);
    check("t6_stale_req", 32'(imem.req), 32'd1);
    check("t6_stale_addr", imem.addr, 32'h0);
    gnt_block = 1'b0;
    rsp_delay = 1;
    wait_valid("t6_valid", 10);
    check("t6_pc0", ifid_pc, 32'h0);
    check("t6_instr0", ifid_instr, 32'hC0DE_0000);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
